sys_cmd_sequencer: RTL and testbench

Command controller in the REF_CLK domain, between the UART RX data path and the RegFile/ALU datapath. Decodes framed command bytes from UART RX (RegFile write, RegFile read, ALU with operands, ALU without operands). Sequences RegFile accesses, ALU enable and ALU clock gating. Pushes result bytes into the TX async FIFO under FULL backpressure.

---
 rtl/sys_cmd_sequencer_if.sv | 45 ++++
 rtl/sys_cmd_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_sys_cmd_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sys_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : sys_cmd_sequencer_if
// Brief  : UART-RX / RegFile / ALU / TX-FIFO signal bundle of the command sequencer
// Rev    : 1.0 - initial release
// ============================================================================
interface sys_cmd_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    logic [DATA_WIDTH-1:0]   RdData;
    logic                    RdData_Valid;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    OUT_VALID;
    logic                    FULL;
    logic [ADDR_WIDTH-1:0]   Address;
    logic                    WrEn;
    logic                    RdEn;
    logic [DATA_WIDTH-1:0]   WrData;
    logic                    ALU_EN;
    logic [FUN_WIDTH-1:0]    ALU_FUN;
    logic                    CLK_EN;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;
    logic                    BUSY;
    logic                    ERR;

    // Sequencer side
    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_VALID, FULL,
        output Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN,
               TX_P_DATA, TX_D_VLD, BUSY, ERR
    );

    // Environment side (UART RX, RegFile, ALU, TX FIFO)
    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_VALID, FULL,
        input  Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN,
               TX_P_DATA, TX_D_VLD, BUSY, ERR
    );
endinterface
`default_nettype wire

// File: rtl/sys_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : sys_cmd_sequencer
// Brief  : Decodes framed UART command bytes, sequences RegFile/ALU, pushes results to TX FIFO
// Rev    : 1.0 - initial release
// ============================================================================
module sys_cmd_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                REF_CLK,
    input  logic                RST,
    sys_cmd_sequencer_if.master bus
);

    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0]    c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] c_CMD_WR   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] c_CMD_RD   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] c_CMD_ALU  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] c_CMD_ALUN = DATA_WIDTH'(8'hDD);
    localparam logic [ADDR_WIDTH-1:0] c_OPA_ADDR = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] c_OPB_ADDR = ADDR_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_ADDR  = 4'd1,
        S_WR_DATA  = 4'd2,
        S_RD_ADDR  = 4'd3,
        S_RD_WAIT  = 4'd4,
        S_OPA      = 4'd5,
        S_OPB      = 4'd6,
        S_FUN      = 4'd7,
        S_ALU_WAIT = 4'd8,
        S_SEND_RD  = 4'd9,
        S_SEND_LO  = 4'd10,
        S_SEND_HI  = 4'd11
    } state_t;

    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [2*DATA_WIDTH-1:0] r_alu_res;
    logic [ADDR_WIDTH-1:0]   r_address;
    logic                    r_wren;
    logic                    r_rden;
    logic [DATA_WIDTH-1:0]   r_wrdata;
    logic                    r_alu_en;
    logic [FUN_WIDTH-1:0]    r_alu_fun;
    logic                    r_clk_en;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_tx_vld;
    logic                    r_busy;
    logic                    r_err;

    wire logic               w_rx_vld  = bus.RX_D_VLD;
    wire logic [DATA_WIDTH-1:0] w_rx_byte = bus.RX_P_DATA;
    wire logic               w_expired = (r_cnt == c_CNT_LAST);

    always_ff @(posedge REF_CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_alu_res <= '0;
            r_address <= '0;
            r_wren    <= 1'b0;
            r_rden    <= 1'b0;
            r_wrdata  <= '0;
            r_alu_en  <= 1'b0;
            r_alu_fun <= '0;
            r_clk_en  <= 1'b0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // Single-cycle strobes default low every cycle
            r_wren   <= 1'b0;
            r_rden   <= 1'b0;
            r_alu_en <= 1'b0;
            r_tx_vld <= 1'b0;
            r_err    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_rx_vld) begin
                        case (w_rx_byte)
                            c_CMD_WR:   begin r_state <= S_WR_ADDR; r_busy <= 1'b1; end
                            c_CMD_RD:   begin r_state <= S_RD_ADDR; r_busy <= 1'b1; end
                            c_CMD_ALU:  begin r_state <= S_OPA;     r_busy <= 1'b1; end
                            c_CMD_ALUN: begin r_state <= S_FUN;     r_busy <= 1'b1; end
                            default:    r_state <= S_IDLE;
                        endcase
                    end
                end

                S_WR_ADDR: begin
                    if (w_rx_vld) begin
                        r_address <= w_rx_byte[ADDR_WIDTH-1:0];
                        r_state   <= S_WR_DATA;
                    end
                end

                S_WR_DATA: begin
                    if (w_rx_vld) begin
                        r_wren   <= 1'b1;
                        r_wrdata <= w_rx_byte;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
                end

                S_RD_ADDR: begin
                    if (w_rx_vld) begin
                        r_rden    <= 1'b1;
                        r_address <= w_rx_byte[ADDR_WIDTH-1:0];
                        r_cnt     <= '0;
                        r_state   <= S_RD_WAIT;
                    end
                end

                // A strobe in the expiry cycle wins over the timeout
                S_RD_WAIT: begin
                    if (bus.RdData_Valid) begin
                        r_tx_data <= bus.RdData;
                        r_state   <= S_SEND_RD;
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_OPA: begin
                    if (w_rx_vld) begin
                        r_wren    <= 1'b1;
                        r_address <= c_OPA_ADDR;
                        r_wrdata  <= w_rx_byte;
                        r_state   <= S_OPB;
                    end
                end

                S_OPB: begin
                    if (w_rx_vld) begin
                        r_wren    <= 1'b1;
                        r_address <= c_OPB_ADDR;
                        r_wrdata  <= w_rx_byte;
                        r_state   <= S_FUN;
                    end
                end

                S_FUN: begin
                    if (w_rx_vld) begin
                        r_alu_fun <= w_rx_byte[FUN_WIDTH-1:0];
                        r_alu_en  <= 1'b1;
                        r_clk_en  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_ALU_WAIT;
                    end
                end

                S_ALU_WAIT: begin
                    if (bus.OUT_VALID) begin
                        r_alu_res <= bus.ALU_OUT;
                        r_tx_data <= bus.ALU_OUT[DATA_WIDTH-1:0];
                        r_clk_en  <= 1'b0;
                        r_state   <= S_SEND_LO;
                    end else if (w_expired) begin
                        r_err    <= 1'b1;
                        r_clk_en <= 1'b0;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // TX_P_DATA already holds the read byte from the RD_WAIT exit
                S_SEND_RD: begin
                    if (!bus.FULL) begin
                        r_tx_vld <= 1'b1;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
                end

                S_SEND_LO: begin
                    r_tx_data <= r_alu_res[DATA_WIDTH-1:0];
                    if (!bus.FULL) begin
                        r_tx_vld <= 1'b1;
                        r_state  <= S_SEND_HI;
                    end
                end

                S_SEND_HI: begin
                    r_tx_data <= r_alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
                    if (!bus.FULL) begin
                        r_tx_vld <= 1'b1;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
                end

                default: begin
                    r_clk_en <= 1'b0;
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Address   = r_address;
    assign bus.WrEn      = r_wren;
    assign bus.RdEn      = r_rden;
    assign bus.WrData    = r_wrdata;
    assign bus.ALU_EN    = r_alu_en;
    assign bus.ALU_FUN   = r_alu_fun;
    assign bus.CLK_EN    = r_clk_en;
    assign bus.TX_P_DATA = r_tx_data;
    assign bus.TX_D_VLD  = r_tx_vld;
    assign bus.BUSY      = r_busy;
    assign bus.ERR       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sys_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_sys_cmd_sequencer
// Brief  : Directed self-checking bench for sys_cmd_sequencer
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sys_cmd_sequencer;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int FW  = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   tx_cnt = 0;
    int   tx_base;

    sys_cmd_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) bus ();

    sys_cmd_sequencer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FUN_WIDTH  (FW),
        .TIMEOUT    (TMO)
    ) dut (
        .REF_CLK (clk),
        .RST     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.TX_D_VLD === 1'b1) tx_cnt <= tx_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        tick();
        bus.RX_D_VLD  = 1'b0;
    endtask

    function automatic logic [31:0] outs();
        return {1'b0, bus.Address, bus.WrEn, bus.RdEn, bus.WrData, bus.ALU_EN, bus.ALU_FUN,
                bus.CLK_EN, bus.TX_P_DATA, bus.TX_D_VLD, bus.BUSY, bus.ERR};
    endfunction

    initial begin
        bus.RX_P_DATA    = '0;
        bus.RX_D_VLD     = 1'b0;
        bus.RdData       = '0;
        bus.RdData_Valid = 1'b0;
        bus.ALU_OUT      = '0;
        bus.OUT_VALID    = 1'b0;
        bus.FULL         = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset_outputs", outs(), 32'h0);
        rst = 1'b0;
        tick();

        // Write: AA,05,3C
        tx_base = tx_cnt;
        send(8'hAA);
        check("wr_busy", {31'h0, bus.BUSY}, 32'h1);
        send(8'h05);
        send(8'h3C);
        check("wr_wren",  {31'h0, bus.WrEn},  32'h1);
        check("wr_addr",  {28'h0, bus.Address}, 32'h5);
        check("wr_data",  {24'h0, bus.WrData},  32'h3C);
        check("wr_idle",  {31'h0, bus.BUSY},  32'h0);
        tick();
        check("wr_wren_one_cycle", {31'h0, bus.WrEn}, 32'h0);
        check("wr_no_tx", tx_cnt - tx_base, 32'h0);

        // Read: BB,05, RdData 0x3C two cycles after RdEn
        tx_base = tx_cnt;
        send(8'hBB);
        send(8'h05);
        check("rd_rden", {31'h0, bus.RdEn}, 32'h1);
        check("rd_addr", {28'h0, bus.Address}, 32'h5);
        tick();
        check("rd_rden_one_cycle", {31'h0, bus.RdEn}, 32'h0);
        bus.RdData       = 8'h3C;
        bus.RdData_Valid = 1'b1;
        tick();
        bus.RdData_Valid = 1'b0;
        check("rd_no_tx_yet", {31'h0, bus.TX_D_VLD}, 32'h0);
        tick();
        check("rd_tx_vld",  {31'h0, bus.TX_D_VLD}, 32'h1);
        check("rd_tx_data", {24'h0, bus.TX_P_DATA}, 32'h3C);
        check("rd_idle",    {31'h0, bus.BUSY}, 32'h0);
        tick();
        check("rd_push_count", tx_cnt - tx_base, 32'h1);

        // ALU with operands: CC,0A,14,02 -> 0x00C8
        tx_base = tx_cnt;
        send(8'hCC);
        send(8'h0A);
        check("opa_write", {19'h0, bus.WrEn, bus.Address, bus.WrData}, {19'h0, 1'b1, 4'h0, 8'h0A});
        send(8'h14);
        check("opb_write", {19'h0, bus.WrEn, bus.Address, bus.WrData}, {19'h0, 1'b1, 4'h1, 8'h14});
        send(8'h02);
        check("fun_issue", {26'h0, bus.ALU_EN, bus.CLK_EN, bus.ALU_FUN}, {26'h0, 1'b1, 1'b1, 4'h2});
        tick();
        tick();
        check("alu_wait_clk_en", {30'h0, bus.ALU_EN, bus.CLK_EN}, 32'h1);
        bus.ALU_OUT   = 16'h00C8;
        bus.OUT_VALID = 1'b1;
        tick();
        bus.OUT_VALID = 1'b0;
        check("alu_clk_en_fall", {31'h0, bus.CLK_EN}, 32'h0);
        tick();
        check("alu_tx_lo", {23'h0, bus.TX_D_VLD, bus.TX_P_DATA}, {23'h0, 1'b1, 8'hC8});
        tick();
        check("alu_tx_hi", {23'h0, bus.TX_D_VLD, bus.TX_P_DATA}, {23'h0, 1'b1, 8'h00});
        tick();
        check("alu_done", {30'h0, bus.TX_D_VLD, bus.BUSY}, 32'h0);
        check("alu_push_count", tx_cnt - tx_base, 32'h2);

        // ALU without operands under FULL backpressure
        tx_base = tx_cnt;
        send(8'hDD);
        send(8'h00);
        check("dd_fun", {27'h0, bus.ALU_EN, bus.ALU_FUN}, {27'h0, 1'b1, 4'h0});
        bus.FULL      = 1'b1;
        bus.ALU_OUT   = 16'h1234;
        bus.OUT_VALID = 1'b1;
        tick();
        bus.OUT_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("full_hold", {23'h0, bus.TX_D_VLD, bus.TX_P_DATA}, {23'h0, 1'b0, 8'h34});
        end
        bus.FULL = 1'b0;
        tick();
        check("full_tx_lo", {23'h0, bus.TX_D_VLD, bus.TX_P_DATA}, {23'h0, 1'b1, 8'h34});
        tick();
        check("full_tx_hi", {23'h0, bus.TX_D_VLD, bus.TX_P_DATA}, {23'h0, 1'b1, 8'h12});
        tick();
        check("full_push_count", tx_cnt - tx_base, 32'h2);

        // ALU timeout; an RX byte during the wait must be dropped
        tx_base = tx_cnt;
        send(8'hDD);
        send(8'h01);
        for (int i = 0; i < TMO - 1; i++) begin
            bus.RX_P_DATA = 8'hAA;
            bus.RX_D_VLD  = (i == 3);
            tick();
        end
        bus.RX_D_VLD = 1'b0;
        check("tmo_before", {30'h0, bus.ERR, bus.CLK_EN}, 32'h1);
        tick();
        check("tmo_err", {29'h0, bus.ERR, bus.CLK_EN, bus.BUSY}, {29'h0, 3'b100});
        tick();
        check("tmo_err_pulse", {31'h0, bus.ERR}, 32'h0);
        send(8'h55);
        check("unknown_ignored", {31'h0, bus.BUSY}, 32'h0);
        bus.OUT_VALID = 1'b1;
        tick();
        bus.OUT_VALID = 1'b0;
        tick();
        check("stray_strobe", {31'h0, bus.BUSY}, 32'h0);
        check("tmo_no_tx", tx_cnt - tx_base, 32'h0);

        // Strobe in the expiry cycle beats the timeout
        send(8'hBB);
        send(8'h03);
        repeat (TMO - 1) tick();
        bus.RdData       = 8'hA5;
        bus.RdData_Valid = 1'b1;
        tick();
        bus.RdData_Valid = 1'b0;
        check("edge_no_err", {30'h0, bus.ERR, bus.BUSY}, 32'h1);
        tick();
        check("edge_tx", {23'h0, bus.TX_D_VLD, bus.TX_P_DATA}, {23'h0, 1'b1, 8'hA5});

        // Reset in OPB, then a normal write
        tick();
        send(8'hCC);
        send(8'h0A);
        rst = 1'b1;
        #1;
        check("rst_mid_cmd", outs(), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        send(8'hAA);
        send(8'h01);
        send(8'hFF);
        check("post_rst_write", {18'h0, bus.WrEn, bus.Address, bus.WrData, bus.BUSY},
              {18'h0, 1'b1, 4'h1, 8'hFF, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
